// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
// Contents: one-hot op encodings, op-class masks, FSM state enum, iteration counts, special-case constants.
// Helpers: 32->64 sign extension and W-op result formatting.
package muldiv_pkg;

    localparam int unsigned OP_W = 13;

    // One-hot op encodings, bit order matches in_muldiv_type
    localparam logic [OP_W-1:0] OP_MUL    = 13'h0001;
    localparam logic [OP_W-1:0] OP_MULH   = 13'h0002;
    localparam logic [OP_W-1:0] OP_MULHSU = 13'h0004;
    localparam logic [OP_W-1:0] OP_MULHU  = 13'h0008;
    localparam logic [OP_W-1:0] OP_MULW   = 13'h0010;
    localparam logic [OP_W-1:0] OP_DIV    = 13'h0020;
    localparam logic [OP_W-1:0] OP_DIVU   = 13'h0040;
    localparam logic [OP_W-1:0] OP_REM    = 13'h0080;
    localparam logic [OP_W-1:0] OP_REMU   = 13'h0100;
    localparam logic [OP_W-1:0] OP_DIVW   = 13'h0200;
    localparam logic [OP_W-1:0] OP_DIVUW  = 13'h0400;
    localparam logic [OP_W-1:0] OP_REMW   = 13'h0800;
    localparam logic [OP_W-1:0] OP_REMUW  = 13'h1000;

    localparam int unsigned MD_MUL    = 0;
    localparam int unsigned MD_MULH   = 1;
    localparam int unsigned MD_MULHSU = 2;
    localparam int unsigned MD_MULW   = 4;

    localparam logic [OP_W-1:0] MUL_MASK  = OP_MUL | OP_MULH | OP_MULHSU | OP_MULHU | OP_MULW;
    localparam logic [OP_W-1:0] W_MASK    = OP_MULW | OP_DIVW | OP_DIVUW | OP_REMW | OP_REMUW;
    localparam logic [OP_W-1:0] SDIV_MASK = OP_DIV | OP_REM | OP_DIVW | OP_REMW;
    localparam logic [OP_W-1:0] REM_MASK  = OP_REM | OP_REMU | OP_REMW | OP_REMUW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int unsigned ITER_X = 64;
    localparam int unsigned ITER_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam logic [CNT_W-1:0] CNT_LAST_X = CNT_W'(ITER_X - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_W = CNT_W'(ITER_W - 1);

    // Signed-overflow dividends (most negative values)
    localparam logic [63:0] MIN_X = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN_W = 32'h8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // W ops return the low word sign-extended; full-width ops pass through
    function automatic logic [63:0] fmt_res(input logic [63:0] x, input logic w);
        return w ? sext32(x[31:0]) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/flush/writeback bundle between the scheduler and the mul/div unit.
// master: issuer side (drives in_*, flush_*, out_ready); slave: the unit.
// Issue and writeback are valid/ready; flush is a one-cycle valid with robid.
interface muldiv_if #(
    parameter int ROBID_W = 7,
    parameter int XLEN    = 64,
    parameter int PREG_W  = 7
);
    logic               in_valid;
    logic               in_ready;
    logic [ROBID_W-1:0] in_robid;
    logic [PREG_W-1:0]  in_prd;
    logic               in_need_to_wb;
    logic [XLEN-1:0]    in_src1;
    logic [XLEN-1:0]    in_src2;
    logic [12:0]        in_muldiv_type;
    logic               flush_valid;
    logic [ROBID_W-1:0] flush_robid;
    logic               out_valid;
    logic               out_ready;
    logic [ROBID_W-1:0] out_robid;
    logic [PREG_W-1:0]  out_prd;
    logic               out_need_to_wb;
    logic [XLEN-1:0]    out_result;
    logic               busy;

    modport master (
        output in_valid, in_robid, in_prd, in_need_to_wb, in_src1, in_src2, in_muldiv_type,
        output flush_valid, flush_robid, out_ready,
        input  in_ready, out_valid, out_robid, out_prd, out_need_to_wb, out_result, busy
    );

    modport slave (
        input  in_valid, in_robid, in_prd, in_need_to_wb, in_src1, in_src2, in_muldiv_type,
        input  flush_valid, flush_robid, out_ready,
        output in_ready, out_valid, out_robid, out_prd, out_need_to_wb, out_result, busy
    );
endinterface

// File: rtl/muldiv_div_iter.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational. Backpressure: none.
// Ports: rem_i/dvd_bit_i/dvsr_i in; rem_o (next partial remainder), q_o (quotient bit) out.
module muldiv_div_iter #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_bit_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    // rem_i < dvsr_i always holds, so the trial difference has its top bit set
    // exactly when the subtraction borrows.
    always_comb begin
        part  = {rem_i, dvd_bit_i};
        diff  = part - {1'b0, dvsr_i};
        q_o   = ~diff[XLEN];
        rem_o = q_o ? diff[XLEN-1:0] : part[XLEN-1:0];
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// RV64M multiply/divide unit: single-cycle multiply, radix-2 restoring divide, ROB-ordered flush.
// Latency: MUL 2, special-case div 1, DIV 65 (W ops 33) cycles from accept to out_valid.
// Backpressure: one op at a time; in_ready only in IDLE; result held in DONE until out_ready.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int ROBID_W = 7,
    parameter int XLEN    = 64,
    parameter int PREG_W  = 7
) (
    input  logic    clock,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int MSB = ROBID_W - 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OP_W-1:0]    op_q;
    logic [ROBID_W-1:0] robid_q;
    logic [PREG_W-1:0]  prd_q;
    logic               wb_q;
    logic [XLEN-1:0]    result_q;
    logic [XLEN-1:0]    rem_q;
    logic [XLEN-1:0]    quot_q;   // multiplicand for MUL, shifting dividend/quotient for DIV
    logic [XLEN-1:0]    dvsr_q;   // multiplier for MUL, divisor magnitude for DIV
    logic               negq_q;
    logic               negr_q;

    // Kill when the flush robid is older than r; equal robid survives.
    function automatic logic kill_f(input logic fv, input logic [ROBID_W-1:0] f,
                                    input logic [ROBID_W-1:0] r);
        return fv && ((f[MSB] ^ r[MSB]) ^ (f[MSB-1:0] < r[MSB-1:0]));
    endfunction

    logic kill_in, kill_held, accept;
    assign kill_in   = kill_f(bus.flush_valid, bus.flush_robid, bus.in_robid);
    assign kill_held = kill_f(bus.flush_valid, bus.flush_robid, robid_q);
    assign accept    = bus.in_valid && bus.in_ready && !kill_in;

    assign bus.in_ready       = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.out_valid      = (state_q == S_DONE) && !kill_held;
    assign bus.out_robid      = robid_q;
    assign bus.out_prd        = prd_q;
    assign bus.out_need_to_wb = wb_q;
    assign bus.out_result     = result_q;

    // Issue-side decode and divide special cases
    logic            in_w, in_mul, in_sgn, in_rem, div0, ovf;
    logic [XLEN-1:0] dvd_in, dvs_in, abs_dvd, abs_dvs, spec_res_d;

    always_comb begin
        in_w   = |(bus.in_muldiv_type & W_MASK);
        in_mul = |(bus.in_muldiv_type & MUL_MASK);
        in_sgn = |(bus.in_muldiv_type & SDIV_MASK);
        in_rem = |(bus.in_muldiv_type & REM_MASK);
        if (in_w) begin
            dvd_in = in_sgn ? sext32(bus.in_src1[31:0]) : {32'b0, bus.in_src1[31:0]};
            dvs_in = in_sgn ? sext32(bus.in_src2[31:0]) : {32'b0, bus.in_src2[31:0]};
        end else begin
            dvd_in = bus.in_src1;
            dvs_in = bus.in_src2;
        end
        abs_dvd = (in_sgn && dvd_in[XLEN-1]) ? -dvd_in : dvd_in;
        abs_dvs = (in_sgn && dvs_in[XLEN-1]) ? -dvs_in : dvs_in;
        div0    = (dvs_in == '0);
        ovf     = in_sgn && (dvd_in == (in_w ? sext32(MIN_W) : MIN_X)) && (dvs_in == '1);
        if (in_rem) spec_res_d = div0 ? dvd_in : '0;
        else        spec_res_d = div0 ? '1 : dvd_in;
        spec_res_d = fmt_res(spec_res_d, in_w);
    end

    // Iteration datapath and multiplier
    logic              q_bit, op_w, op_rem, last;
    logic [XLEN-1:0]   rem_d, quot_d, q_fin, r_fin, div_res_d, mul_res_d;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    muldiv_div_iter #(.XLEN(XLEN)) u_iter (
        .rem_i     (rem_q),
        .dvd_bit_i (quot_q[XLEN-1]),
        .dvsr_i    (dvsr_q),
        .rem_o     (rem_d),
        .q_o       (q_bit)
    );

    always_comb begin
        op_w      = |(op_q & W_MASK);
        op_rem    = |(op_q & REM_MASK);
        last      = (cnt_q == (op_w ? CNT_LAST_W : CNT_LAST_X));
        quot_d    = {quot_q[XLEN-2:0], q_bit};
        // Sign fix-up applied to the final step's values directly
        q_fin     = negq_q ? -quot_d : quot_d;
        r_fin     = negr_q ? -rem_d : rem_d;
        div_res_d = fmt_res(op_rem ? r_fin : q_fin, op_w);
        // Operands extended to full product width; low 2*XLEN bits are exact for all sign mixes
        mul_a = {{XLEN{(op_q[MD_MULH] | op_q[MD_MULHSU]) & quot_q[XLEN-1]}}, quot_q};
        mul_b = {{XLEN{op_q[MD_MULH] & dvsr_q[XLEN-1]}}, dvsr_q};
        prod  = mul_a * mul_b;
        if (op_q[MD_MUL])       mul_res_d = prod[XLEN-1:0];
        else if (op_q[MD_MULW]) mul_res_d = sext32(prod[31:0]);
        else                    mul_res_d = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            robid_q  <= '0;
            prd_q    <= '0;
            wb_q     <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.in_muldiv_type;
                        robid_q <= bus.in_robid;
                        prd_q   <= bus.in_prd;
                        wb_q    <= bus.in_need_to_wb;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        if (in_mul) begin
                            quot_q  <= bus.in_src1;
                            dvsr_q  <= bus.in_src2;
                            state_q <= S_MUL;
                        end else if (div0 || ovf) begin
                            result_q <= spec_res_d;
                            state_q  <= S_DONE;
                        end else begin
                            // W ops park the 32-bit magnitude in the top half so 32 shifts consume it
                            quot_q  <= in_w ? {abs_dvd[31:0], 32'b0} : abs_dvd;
                            dvsr_q  <= abs_dvs;
                            negq_q  <= in_sgn && (dvd_in[XLEN-1] ^ dvs_in[XLEN-1]);
                            negr_q  <= in_sgn && dvd_in[XLEN-1];
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (kill_held) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= mul_res_d;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (kill_held) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (last) begin
                        result_q <= div_res_d;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // A kill suppresses out_valid, so flush wins over a same-cycle out_ready
                    if (kill_held || bus.out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, tags, flush, backpressure and reset.
// Latency: counted in cycles from the accept cycle (cycle 0).
// Backpressure: out_ready held low except where a handshake is intended.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    muldiv_if #(.ROBID_W(7), .XLEN(64), .PREG_W(7)) bus ();

    muldiv_ctrl #(.ROBID_W(7), .XLEN(64), .PREG_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          lat;
    int          seen;
    logic [63:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [6:0] rid);
        bus.in_valid       = 1'b1;
        bus.in_muldiv_type = op;
        bus.in_src1        = a;
        bus.in_src2        = b;
        bus.in_robid       = rid;
        bus.in_prd         = rid ^ 7'h2A;
        bus.in_need_to_wb  = rid[0];
        tick();
        bus.in_valid       = 1'b0;
    endtask

    task automatic wait_out(input int from, output int l);
        l = from;
        while (bus.out_valid !== 1'b1 && l < 200) begin
            tick();
            l++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [12:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [6:0] rid, input int exp_lat,
                       input logic [63:0] exp_res);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        start(op, a, b, rid);
        wait_out(1, lat);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, bus.out_result, exp_res);
        chk({tag, " robid"}, 64'(bus.out_robid), 64'(rid));
        chk({tag, " prd"}, 64'(bus.out_prd), 64'(rid ^ 7'h2A));
        chk({tag, " wb"}, 64'(bus.out_need_to_wb), 64'(rid[0]));
        drain();
        chk({tag, " back to idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_robid       = '0;
        bus.in_prd         = '0;
        bus.in_need_to_wb  = 1'b0;
        bus.in_src1        = '0;
        bus.in_src2        = '0;
        bus.in_muldiv_type = '0;
        bus.flush_valid    = 1'b0;
        bus.flush_robid    = '0;
        bus.out_ready      = 1'b0;
        reset              = 1'b1;
        tick();
        tick();
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_result", bus.out_result, 64'd0);
        chk("reset out_robid", 64'(bus.out_robid), 64'd0);
        chk("reset out_prd", 64'(bus.out_prd), 64'd0);
        chk("reset out_wb", 64'(bus.out_need_to_wb), 64'd0);
        reset = 1'b0;
        tick();

        run("divu 100/7", OP_DIVU, 64'd100, 64'd7, 7'h01, 65, 64'd14);
        run("remu 100/7", OP_REMU, 64'd100, 64'd7, 7'h02, 65, 64'd2);
        run("div min/-1", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7'h03, 1,
            64'h8000_0000_0000_0000);
        run("rem min/-1", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7'h04, 1, 64'd0);
        run("divw 5/0", OP_DIVW, 64'd5, 64'd0, 7'h05, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remw -7/0", OP_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 7'h06, 1, 64'hFFFF_FFFF_FFFF_FFF9);
        run("divw min/-1", OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 7'h07, 1,
            64'hFFFF_FFFF_8000_0000);
        run("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 7'h08, 2, 64'd1);
        run("mulw", OP_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 7'h09, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        run("mul 3*5", OP_MUL, 64'd3, 64'd5, 7'h0A, 2, 64'd15);
        run("mulh -1*-1", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 7'h0B, 2, 64'd0);
        run("mulhsu -1*max", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 7'h0C, 2,
            64'hFFFF_FFFF_FFFF_FFFF);
        run("div -100/7", OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 7'h0D, 65, 64'hFFFF_FFFF_FFFF_FFF2);
        run("rem -100/7", OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 7'h0E, 65, 64'hFFFF_FFFF_FFFF_FFFE);
        run("divw -100/7", OP_DIVW, 64'h0000_0000_FFFF_FF9C, 64'd7, 7'h0F, 33, 64'hFFFF_FFFF_FFFF_FFF2);
        run("divuw", OP_DIVUW, 64'h0000_0000_FFFF_FF9C, 64'd7, 7'h10, 33, 64'h0000_0000_2492_4916);
        run("remuw", OP_REMUW, 64'h0000_0000_FFFF_FF9C, 64'd7, 7'h11, 33, 64'd2);

        // Older flush kills an in-flight divide at cycle 10
        start(OP_DIV, 64'd100, 64'd7, 7'h45);
        repeat (9) tick();
        bus.flush_valid = 1'b1;
        bus.flush_robid = 7'h43;
        #1;
        chk("flush kill out_valid same cycle", 64'(bus.out_valid), 64'd0);
        tick();
        bus.flush_valid = 1'b0;
        chk("flush kill in_ready cycle 11", 64'(bus.in_ready), 64'd1);
        chk("flush kill busy cycle 11", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (70) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("flush kill no output", 64'(seen), 64'd0);

        // Equal robid is not killed
        start(OP_DIV, 64'd100, 64'd7, 7'h45);
        repeat (9) tick();
        bus.flush_valid = 1'b1;
        bus.flush_robid = 7'h45;
        tick();
        bus.flush_valid = 1'b0;
        wait_out(11, lat);
        chk("flush equal latency", 64'(lat), 64'd65);
        chk("flush equal result", bus.out_result, 64'd14);
        drain();

        // Flush in IDLE on the offered op blocks acceptance
        bus.in_valid       = 1'b1;
        bus.in_muldiv_type = OP_DIVU;
        bus.in_src1        = 64'd9;
        bus.in_src2        = 64'd3;
        bus.in_robid       = 7'h45;
        bus.flush_valid    = 1'b1;
        bus.flush_robid    = 7'h43;
        tick();
        bus.in_valid    = 1'b0;
        bus.flush_valid = 1'b0;
        chk("idle flush not accepted busy", 64'(bus.busy), 64'd0);
        chk("idle flush in_ready", 64'(bus.in_ready), 64'd1);

        // Flush and out_ready together in DONE: flush wins
        start(OP_MUL, 64'd3, 64'd5, 7'h10);
        wait_out(1, lat);
        chk("done flush mul latency", 64'(lat), 64'd2);
        bus.out_ready   = 1'b1;
        bus.flush_valid = 1'b1;
        bus.flush_robid = 7'h0F;
        #1;
        chk("done flush out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.out_ready   = 1'b0;
        bus.flush_valid = 1'b0;
        chk("done flush idle", 64'(bus.in_ready), 64'd1);

        // Hold in DONE under backpressure
        start(OP_DIVU, 64'd1000, 64'd10, 7'h12);
        wait_out(1, lat);
        chk("hold latency", 64'(lat), 64'd65);
        held = bus.out_result;
        chk("hold result", held, 64'd100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold out_result stable", bus.out_result, held);
            chk("hold in_ready low", 64'(bus.in_ready), 64'd0);
        end
        // New op offered in the handshake cycle must not be taken
        bus.in_valid       = 1'b1;
        bus.in_muldiv_type = OP_MUL;
        bus.in_robid       = 7'h13;
        bus.out_ready      = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("handshake idle in_ready", 64'(bus.in_ready), 64'd1);
        chk("handshake no accept", 64'(bus.busy), 64'd0);

        // Reset mid-operation abandons the op
        start(OP_DIV, 64'd100, 64'd7, 7'h20);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset in_ready", 64'(bus.in_ready), 64'd1);
        chk("midreset out_robid", 64'(bus.out_robid), 64'd0);
        seen = 0;
        repeat (80) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("midreset no output", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
